icache_refill_controller: RTL and testbench
===========================================

// Module: icache_refill_controller
// PURPOSE
// - Memory-side stage directly downstream of the instruction cache controller.
// - Serves its block-refill requests (mem_address/mem_valid -> mem_data_in/mem_ready).
// - Per request: fetches DRAM_BLOCK_SIZE words one at a time over a word-wide DRAM read port.
// - Assembles the words into a line buffer, then returns the whole block with a one-cycle ready pulse.
// PARAMETERS
// ADDR_W      `DRAM_ADDRESS_SIZE  byte address width
// WORD_W      `DRAM_WORD_SIZE     data word width (bits, multiple of 8)
// BLOCK_WORDS `DRAM_BLOCK_SIZE    words per cache line, power of 2, >=2
// PORTS
// clock         in   1                  single clock, all state on posedge
// reset         in   1                  synchronous, active-high
// req_address   in   ADDR_W             refill byte address (any word of the line)
// req_valid     in   1                  refill request (cache mem_valid)
// resp_data     out  WORD_W x BLOCK_WORDS  assembled line, unpacked array (to mem_data_in)
// resp_ready    out  1                  one-cycle pulse: resp_data valid (to mem_ready)
// busy          out  1                  high in every state except IDLE
// dram_address  out  ADDR_W             word byte address of the current beat
// dram_read     out  1                  one-cycle read strobe per beat
// dram_rdata    in   WORD_W             DRAM read data
// dram_rvalid   in   1                  dram_rdata valid; latency L>=1 cycles after dram_read
// BEHAVIOUR
// - Reset: state IDLE, beat counter 0, line buffer all-zero.
// - Reset outputs: resp_ready=0, busy=0, dram_read=0, dram_address=0, resp_data=0.
// - Reset at any point aborts a refill. No resp_ready is produced for the aborted request.
// - FSM states: IDLE, ISSUE, WAIT, RESPOND.
// - IDLE: req_valid=1 -> latch base = req_address with low log2(BLOCK_WORDS)+2 bits cleared.
//   Clear beat counter, then go to ISSUE.
// - IDLE: req_valid is a single-cycle pulse from the cache; it must be captured in that cycle.
// - ISSUE (exactly one cycle):
//   dram_read=1, dram_address = base + 4*beat, go to WAIT.
// - WAIT: hold dram_address. On dram_rvalid, write dram_rdata into line[beat]:
//   beat==BLOCK_WORDS-1 -> RESPOND; else beat+1 -> ISSUE.
// - RESPOND (exactly one cycle): resp_ready=1, go to IDLE.
// - resp_data is driven directly from the line buffer register. It holds the last completed line
//   until the next refill overwrites word 0.
// - Latency: request seen in IDLE at cycle 0 -> resp_ready high in cycle BLOCK_WORDS*(L+1)+1.
//   For BLOCK_WORDS=4, L=1 this is cycle 9.
// - Beats are issued in ascending word order from word 0, whatever the requested word.
//   The line base wraps modulo 2^ADDR_W.
// - req_valid while busy=1 is ignored: no re-latch, no queueing. Simulation assertion flags it.
// - dram_rvalid outside WAIT is ignored (spurious/late beats).
// - The DRAM model is reset together with this block, so no stale beats survive a reset.
// - The cache drives mem_valid for one cycle after reset release.
//   That request is serviced normally (harmless refill of the line at req_address).
// - Single outstanding DRAM read; no pipelining of beats.
// STRUCTURE
// - Shared package mem_pkg:
//   - refill_state_t enum {IDLE, ISSUE, WAIT, RESPOND}
//   - line_t (WORD_W x BLOCK_WORDS array type)
//   - localparams OFFSET_W = log2(BLOCK_WORDS)+2 and BEAT_W = log2(BLOCK_WORDS)
//   - the log2 helper function
// - Width macros come from config.sv / constants.sv.
// - One natural sub-module, refill_line_buffer: BLOCK_WORDS x WORD_W register file.
//   Indexed write-enable, synchronous clear, full-array read.
// TESTING
// 1 Reset: hold reset 3 cycles mid-WAIT -> IDLE, busy=0, resp_data=0, no resp_ready pulse afterwards.
// 2 Basic refill: req_address=0x0000_0104, L=1, DRAM word@a = a ^ 0xA5A5_0000:
//   - dram_address sequence 0x100, 0x104, 0x108, 0x10C
//   - resp_ready only in cycle 9
//   - resp_data[2] = 0xA5A5_0108
// 3 Variable latency: L alternating 1/5 per beat -> same data, resp_ready at sum(L_i+1)+1.
//   Exactly 4 dram_read strobes.
// 4 Request while busy: second req_valid (addr 0x200) during WAIT -> ignored.
//   Only line 0x100 fetched; assertion fires.
// 5 Spurious rvalid: dram_rvalid pulsed in IDLE and ISSUE -> line buffer unchanged, no beat advance.
// 6 Back-to-back: new req_valid the cycle after resp_ready (0xFFFF_FFF0 line) ->
//   - accepted
//   - addresses 0xFFFF_FFF0..0xFFFF_FFFC
//   - previous resp_data stable until overwritten

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory-side refill path: FSM states,
// the cache line type and the address/beat field widths.
package mem_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 4;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    localparam int BEAT_W   = log2_ceil(BLOCK_WORDS);
    localparam int OFFSET_W = BEAT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } refill_state_t;

    typedef logic [WORD_W-1:0] line_t [BLOCK_WORDS];

endpackage

// File: rtl/refill_line_buffer.sv
// Cache line assembly register file: one word written per DRAM beat,
// the whole line read out in parallel.
module refill_line_buffer
    import mem_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              write_en,
    input  logic [BEAT_W-1:0] write_index,
    input  logic [WORD_W-1:0] write_data,
    output line_t             read_data
);

    line_t line_q;
    line_t line_d;

    always_comb begin
        line_d = line_q;
        if (clear) begin
            line_d = '{default: '0};
        end else if (write_en) begin
            line_d[write_index] = write_data;
        end
    end

    always_ff @(posedge clock) begin
        line_q <= line_d;
    end

    assign read_data = line_q;

endmodule

// File: rtl/icache_refill_controller.sv
// Refills one instruction cache line per request by reading it word by word
// from DRAM, then hands the whole line back with a one-cycle ready pulse.
module icache_refill_controller
    import mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_address,
    input  logic              req_valid,
    output line_t             resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] dram_address,
    output logic              dram_read,
    input  logic [WORD_W-1:0] dram_rdata,
    input  logic              dram_rvalid
);

    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    refill_state_t     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] dram_address_q, dram_address_d;
    logic              dram_read_q, dram_read_d;
    logic              resp_ready_q, resp_ready_d;
    logic              line_write_en;

    assign line_write_en = (state_q == WAIT) && dram_rvalid;

    // Outputs are computed one cycle early so that they come straight from flops.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        base_d         = base_q;
        dram_address_d = dram_address_q;
        dram_read_d    = 1'b0;
        resp_ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d         = req_address & BASE_MASK;
                    beat_d         = '0;
                    dram_address_d = base_d;
                    dram_read_d    = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dram_rvalid) begin
                    if (beat_q == LAST_BEAT) begin
                        resp_ready_d = 1'b1;
                        state_d      = RESPOND;
                    end else begin
                        beat_d         = beat_q + BEAT_W'(1);
                        dram_address_d = base_q + ADDR_W'({beat_d, 2'b00});
                        dram_read_d    = 1'b1;
                        state_d        = ISSUE;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            base_q         <= '0;
            dram_address_q <= '0;
            dram_read_q    <= 1'b0;
            resp_ready_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            base_q         <= base_d;
            dram_address_q <= dram_address_d;
            dram_read_q    <= dram_read_d;
            resp_ready_q   <= resp_ready_d;
        end
    end

    refill_line_buffer u_line_buffer (
        .clock       (clock),
        .clear       (reset),
        .write_en    (line_write_en),
        .write_index (beat_q),
        .write_data  (dram_rdata),
        .read_data   (resp_data)
    );

    assign busy         = (state_q != IDLE);
    assign resp_ready   = resp_ready_q;
    assign dram_read    = dram_read_q;
    assign dram_address = dram_address_q;

    // A request arriving mid-refill is dropped rather than queued; flag it in simulation.
    always_ff @(posedge clock) begin
        if (!reset && req_valid) begin
            assert (!busy) else $warning("req_valid ignored: refill already in progress");
        end
    end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench for icache_refill_controller: a latency-programmable DRAM
// model plus queues of expected beat addresses and expected returned lines.
module tb_icache_refill_controller;
    import mem_pkg::*;

    typedef struct {
        line_t words;
        int    cycle;
    } resp_exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] req_address = '0;
    logic              req_valid = 1'b0;
    line_t             resp_data;
    logic              resp_ready;
    logic              busy;
    logic [ADDR_W-1:0] dram_address;
    logic              dram_read;
    logic [WORD_W-1:0] dram_rdata = '0;
    logic              dram_rvalid = 1'b0;

    int total_checks  = 0;
    int passed_checks = 0;
    int cycle         = 0;
    int resp_count    = 0;
    int read_count    = 0;
    int pend_count    = 0;
    int model_beat    = 0;
    int spurious_req  = 0;
    int spurious_done = 0;
    bit alt_latency   = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    resp_exp_t         exp_resp_q[$];

    icache_refill_controller dut (
        .clock        (clock),
        .reset        (reset),
        .req_address  (req_address),
        .req_valid    (req_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .dram_address (dram_address),
        .dram_read    (dram_read),
        .dram_rdata   (dram_rdata),
        .dram_rvalid  (dram_rvalid)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cycle = cycle + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks = total_checks + 1;
        if (observed === expected) begin
            passed_checks = passed_checks + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic logic [WORD_W-1:0] dram_word(input logic [ADDR_W-1:0] addr);
        return WORD_W'(addr) ^ WORD_W'(32'hA5A5_0000);
    endfunction

    function automatic int beat_latency(input int beat);
        return (alt_latency && (beat % 2 == 1)) ? 5 : 1;
    endfunction

    // DRAM model: one outstanding read, data returned beat_latency cycles after the strobe.
    initial forever begin
        @(negedge clock);
        dram_rvalid = 1'b0;
        if (reset) begin
            pend_count = 0;
            model_beat = 0;
        end else begin
            if (pend_count > 0) begin
                pend_count = pend_count - 1;
                if (pend_count == 0) begin
                    dram_rvalid = 1'b1;
                    dram_rdata  = dram_word(pend_addr);
                end
            end
            if (spurious_req != spurious_done) begin
                spurious_done = spurious_req;
                dram_rvalid   = 1'b1;
                dram_rdata    = 32'hDEAD_BEEF;
            end
            if (dram_read) begin
                read_count = read_count + 1;
                if (exp_addr_q.size() == 0) begin
                    check_output("unexpected_read", 1, 0);
                end else begin
                    check_output("dram_address", dram_address, exp_addr_q.pop_front());
                end
                pend_addr  = dram_address;
                pend_count = beat_latency(model_beat);
                model_beat = (model_beat + 1) % BLOCK_WORDS;
            end
        end
    end

    // Response monitor: every ready pulse must match the oldest expected line and cycle.
    initial forever begin
        resp_exp_t e;
        @(negedge clock);
        if (!reset && resp_ready) begin
            resp_count = resp_count + 1;
            if (exp_resp_q.size() == 0) begin
                check_output("unexpected_resp", 1, 0);
            end else begin
                e = exp_resp_q.pop_front();
                check_output("resp_cycle", cycle, e.cycle);
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    check_output($sformatf("resp_word%0d", i), resp_data[i], e.words[i]);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input bit spurious_in_issue);
        logic [ADDR_W-1:0] base;
        resp_exp_t         e;
        int                total;
        base  = addr & ~ADDR_W'((1 << OFFSET_W) - 1);
        total = 1;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            exp_addr_q.push_back(base + ADDR_W'(4 * i));
            e.words[i] = dram_word(base + ADDR_W'(4 * i));
            total      = total + beat_latency(i) + 1;
        end
        @(negedge clock);
        e.cycle = cycle + total;
        exp_resp_q.push_back(e);
        req_address = addr;
        req_valid   = 1'b1;
        @(posedge clock);
        #1;
        if (spurious_in_issue) begin
            spurious_req = spurious_req + 1;
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_for_resp(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n = n + 1;
        end while (!resp_ready && n < budget);
        if (!resp_ready) begin
            check_output("resp_timeout", 0, 1);
        end
    endtask

    initial begin
        int r0;
        int rd0;
        line_t prev;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_output("reset_busy", busy, 0);
        check_output("reset_resp_ready", resp_ready, 0);
        check_output("reset_dram_read", dram_read, 0);
        check_output("reset_dram_address", dram_address, 0);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            check_output($sformatf("reset_line%0d", i), resp_data[i], 0);
        end

        // Basic refill of line 0x100
        $display("[TB] basic refill");
        r0  = resp_count;
        rd0 = read_count;
        apply_stimulus(32'h0000_0104, 1'b0);
        wait_for_resp(40);
        @(negedge clock);
        check_output("basic_word2", resp_data[2], 32'hA5A5_0108);
        check_output("basic_pulse_width", resp_ready, 0);
        check_output("basic_resp_count", resp_count - r0, 1);
        check_output("basic_read_count", read_count - rd0, 4);

        // Reset held for three cycles in the middle of WAIT
        $display("[TB] reset mid-refill");
        apply_stimulus(32'h0000_0300, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        exp_addr_q.delete();
        exp_resp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_output("abort_busy", busy, 0);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            check_output($sformatf("abort_line%0d", i), resp_data[i], 0);
        end
        r0  = resp_count;
        rd0 = read_count;
        repeat (15) @(negedge clock);
        check_output("abort_no_resp", resp_count - r0, 0);
        check_output("abort_no_read", read_count - rd0, 0);

        // Latency alternating 1/5 per beat
        $display("[TB] variable latency");
        alt_latency = 1'b1;
        rd0 = read_count;
        apply_stimulus(32'h0000_0104, 1'b0);
        wait_for_resp(60);
        alt_latency = 1'b0;
        @(negedge clock);
        check_output("varlat_read_count", read_count - rd0, 4);

        // Second request while busy is ignored
        $display("[TB] request while busy");
        r0  = resp_count;
        rd0 = read_count;
        apply_stimulus(32'h0000_0104, 1'b0);
        @(negedge clock);
        req_address = 32'h0000_0200;
        req_valid   = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        wait_for_resp(40);
        repeat (15) @(negedge clock);
        check_output("busy_resp_count", resp_count - r0, 1);
        check_output("busy_read_count", read_count - rd0, 4);
        check_output("busy_addr_queue", exp_addr_q.size(), 0);

        // Spurious rvalid in IDLE, then in ISSUE
        $display("[TB] spurious rvalid");
        r0 = resp_count;
        @(posedge clock);
        #1;
        spurious_req = spurious_req + 1;
        repeat (3) @(negedge clock);
        check_output("spur_idle_busy", busy, 0);
        check_output("spur_idle_resp", resp_count - r0, 0);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            check_output($sformatf("spur_idle_line%0d", i), resp_data[i], dram_word(32'h100 + 32'(4 * i)));
        end
        apply_stimulus(32'h0000_0104, 1'b1);
        wait_for_resp(40);
        @(negedge clock);

        // Back-to-back request into the wrapping top line
        $display("[TB] back-to-back");
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            prev[i] = dram_word(32'h100 + 32'(4 * i));
        end
        apply_stimulus(32'h0000_0104, 1'b0);
        wait_for_resp(40);
        apply_stimulus(32'hFFFF_FFF4, 1'b0);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            check_output($sformatf("b2b_hold_line%0d", i), resp_data[i], prev[i]);
        end
        @(negedge clock);
        check_output("b2b_hold_word0_wait", resp_data[0], prev[0]);
        wait_for_resp(40);
        @(negedge clock);
        check_output("b2b_top_word3", resp_data[3], 32'h5A5A_FFFC);

        repeat (3) @(negedge clock);
        check_output("final_addr_queue", exp_addr_q.size(), 0);
        check_output("final_resp_queue", exp_resp_q.size(), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #100000;
        check_output("watchdog", 0, 1);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
